// File: rtl/freq_meas_if.sv
// Handshake and result bus between the frequency-measurement sequencer and its consumer.
interface freq_meas_if #(
  parameter int unsigned WIDTH = 12
);
  logic             start;
  logic             cont;
  logic             ready;
  logic             busy;
  logic             valid;
  logic             err;
  logic [WIDTH-1:0] on_count;
  logic [WIDTH-1:0] off_count;
  logic [WIDTH-1:0] bnum;

  modport master (
    output start, cont, ready,
    input  busy, valid, err, on_count, off_count, bnum
  );

  modport slave (
    input  start, cont, ready,
    output busy, valid, err, on_count, off_count, bnum
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Measures one high/low cycle of an asynchronous input and converts the period into a
// frequency code with a restoring divider; results leave through a valid/ready handshake.
module freq_meas_ctrl #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned NUM_W     = 24,
  parameter int unsigned NUMERATOR = 40960
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN,
  freq_meas_if.slave  bus
);

  localparam int unsigned PW = WIDTH + 1;
  localparam int unsigned RW = WIDTH + 2;
  localparam int unsigned CW = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_LOW  = 3'd3;
  localparam logic [2:0] S_DIV  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [2:0]       state, state_nxt;
  logic             s_meta, s, p;
  logic             rise, fall;

  logic [WIDTH-1:0] on_q, on_nxt;
  logic [WIDTH-1:0] off_q, off_nxt;
  logic [WIDTH-1:0] bnum_q, bnum_nxt;
  logic             err_q, err_nxt;
  logic             busy_q, busy_nxt;
  logic             valid_q, valid_nxt;
  logic [RW-1:0]    rem_q, rem_nxt;
  logic [NUM_W-1:0] dvd_q, dvd_nxt;
  logic [CW-1:0]    it_q, it_nxt;

  logic [PW-1:0]    period;
  logic [RW-1:0]    trial;
  logic [RW-1:0]    rem_sub;
  logic             q_bit;
  logic [NUM_W-1:0] quo_fin;

  assign rise = s & ~p;
  assign fall = ~s & p;

  // Divider step: shift the next dividend bit into the partial remainder and try a subtract.
  assign period  = PW'(on_q) + PW'(off_q);
  assign trial   = {rem_q[RW-2:0], dvd_q[NUM_W-1]};
  assign q_bit   = (trial >= RW'(period));
  assign rem_sub = q_bit ? (trial - RW'(period)) : trial;
  assign quo_fin = {dvd_q[NUM_W-2:0], q_bit};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    on_nxt    = on_q;
    off_nxt   = off_q;
    bnum_nxt  = bnum_q;
    err_nxt   = err_q;
    rem_nxt   = rem_q;
    dvd_nxt   = dvd_q;
    it_nxt    = it_q;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_ARM;
          on_nxt    = '0;
          off_nxt   = '0;
          bnum_nxt  = '0;
          err_nxt   = 1'b0;
        end
      end

      S_ARM: begin
        if (rise) begin
          state_nxt = S_HIGH;
          on_nxt    = WIDTH'(1);
          off_nxt   = '0;
        end
      end

      S_HIGH: begin
        if (fall) begin
          state_nxt = S_LOW;
          off_nxt   = WIDTH'(1);
        end else if (s) begin
          if (on_q == CNT_MAX) begin
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
            bnum_nxt  = '0;
          end else begin
            on_nxt = on_q + WIDTH'(1);
          end
        end
      end

      S_LOW: begin
        if (rise) begin
          state_nxt = S_DIV;
          rem_nxt   = '0;
          dvd_nxt   = NUM_W'(NUMERATOR);
          it_nxt    = '0;
        end else if (!s) begin
          if (off_q == CNT_MAX) begin
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
            bnum_nxt  = '0;
          end else begin
            off_nxt = off_q + WIDTH'(1);
          end
        end
      end

      // Quotient bits shift into the dividend register as its bits are consumed.
      S_DIV: begin
        rem_nxt = rem_sub;
        dvd_nxt = quo_fin;
        it_nxt  = it_q + CW'(1);
        if (it_q == CW'(NUM_W - 1)) begin
          state_nxt = S_DONE;
          bnum_nxt  = (|quo_fin[NUM_W-1:WIDTH]) ? CNT_MAX : quo_fin[WIDTH-1:0];
        end
      end

      S_DONE: begin
        if (bus.ready) begin
          state_nxt = bus.cont ? S_ARM : S_IDLE;
          err_nxt   = 1'b0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt  = (state_nxt != S_IDLE);
    valid_nxt = (state_nxt == S_DONE);
  end

  // Input synchroniser, edge-detect flop and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s_meta  <= 1'b0;
      s       <= 1'b0;
      p       <= 1'b0;
      on_q    <= '0;
      off_q   <= '0;
      bnum_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      it_q    <= '0;
    end else begin
      s_meta  <= IN;
      s       <= s_meta;
      p       <= s;
      on_q    <= on_nxt;
      off_q   <= off_nxt;
      bnum_q  <= bnum_nxt;
      err_q   <= err_nxt;
      busy_q  <= busy_nxt;
      valid_q <= valid_nxt;
      rem_q   <= rem_nxt;
      dvd_q   <= dvd_nxt;
      it_q    <= it_nxt;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.on_count  = on_q;
  assign bus.off_count = off_q;
  assign bus.bnum      = bnum_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl: table of single-shot measurements plus hand sequences
// for reset, backpressure/continuous mode, timeout and reset during the divide.
module tb_freq_meas_ctrl;

  localparam int unsigned WIDTH = 12;
  localparam int          LAT   = 27;

  typedef struct {
    int h;
    int l;
    int exp_on;
    int exp_off;
    int exp_bnum;
    int exp_err;
  } vec_t;

  logic CLK;
  logic RST_N;
  logic in_drv;
  logic osc_en;
  logic osc_in;
  logic in_pin;
  int   osc_cnt;
  int   n_tests;
  int   n_fail;

  freq_meas_if #(.WIDTH(WIDTH)) bus ();

  assign in_pin = osc_en ? osc_in : in_drv;

  freq_meas_ctrl #(
    .WIDTH    (WIDTH),
    .NUM_W    (24),
    .NUMERATOR(40960)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .IN   (in_pin),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Free-running square wave, 10 cycles high / 10 low, used for continuous mode.
  initial begin
    osc_in  = 1'b0;
    osc_cnt = 0;
    forever begin
      @(negedge CLK);
      if (osc_en) begin
        osc_cnt++;
        if (osc_cnt == 10) begin
          osc_in  = ~osc_in;
          osc_cnt = 0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int bound, output int lat);
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!bus.valid && lat < bound);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  vec_t vecs[8];
  int   lat;
  int   n_ok;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    RST_N     = 1'b0;
    in_drv    = 1'b0;
    osc_en    = 1'b0;
    bus.start = 1'b1;
    bus.cont  = 1'b0;
    bus.ready = 1'b1;

    vecs[0] = '{h: 100,  l: 60,  exp_on: 100,  exp_off: 60,  exp_bnum: 256,  exp_err: 0};
    vecs[1] = '{h: 5,    l: 5,   exp_on: 5,    exp_off: 5,   exp_bnum: 4095, exp_err: 0};
    vecs[2] = '{h: 128,  l: 192, exp_on: 128,  exp_off: 192, exp_bnum: 128,  exp_err: 0};
    vecs[3] = '{h: 200,  l: 55,  exp_on: 200,  exp_off: 55,  exp_bnum: 160,  exp_err: 0};
    vecs[4] = '{h: 2,    l: 3,   exp_on: 2,    exp_off: 3,   exp_bnum: 4095, exp_err: 0};
    vecs[5] = '{h: 1000, l: 1000, exp_on: 1000, exp_off: 1000, exp_bnum: 20, exp_err: 0};
    vecs[6] = '{h: 4095, l: 1,   exp_on: 4095, exp_off: 1,   exp_bnum: 10,   exp_err: 0};
    vecs[7] = '{h: 13,   l: 7,   exp_on: 13,   exp_off: 7,   exp_bnum: 2048, exp_err: 0};

    // Reset held with IN toggling and start asserted.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      in_drv = ~in_drv;
    end
    @(posedge CLK);
    #1;
    check("rst_busy",  int'(bus.busy),      0);
    check("rst_valid", int'(bus.valid),     0);
    check("rst_err",   int'(bus.err),       0);
    check("rst_on",    int'(bus.on_count),  0);
    check("rst_off",   int'(bus.off_count), 0);
    check("rst_bnum",  int'(bus.bnum),      0);
    @(negedge CLK);
    bus.start = 1'b0;
    in_drv    = 1'b0;
    RST_N     = 1'b1;
    repeat (5) @(negedge CLK);
    check("post_rst_idle", int'(bus.busy), 0);

    // Single-shot table with ready held high.
    for (int i = 0; i < 8; i++) begin
      pulse_start();
      repeat (2) @(negedge CLK);
      in_drv = 1'b1;
      repeat (vecs[i].h) @(negedge CLK);
      in_drv = 1'b0;
      repeat (vecs[i].l) @(negedge CLK);
      in_drv = 1'b1;
      wait_valid(200, lat);
      check($sformatf("v%0d_valid", i), int'(bus.valid), 1);
      check($sformatf("v%0d_lat", i), lat, LAT);
      check($sformatf("v%0d_on", i), int'(bus.on_count), vecs[i].exp_on);
      check($sformatf("v%0d_off", i), int'(bus.off_count), vecs[i].exp_off);
      check($sformatf("v%0d_bnum", i), int'(bus.bnum), vecs[i].exp_bnum);
      check($sformatf("v%0d_err", i), int'(bus.err), vecs[i].exp_err);
      @(posedge CLK);
      #1;
      check($sformatf("v%0d_pulse", i), int'(bus.valid), 0);
      check($sformatf("v%0d_idle", i), int'(bus.busy), 0);
      @(negedge CLK);
      in_drv = 1'b0;
      repeat (4) @(negedge CLK);
    end

    // Backpressure in continuous mode.
    @(negedge CLK);
    bus.cont  = 1'b1;
    bus.ready = 1'b0;
    pulse_start();
    osc_en = 1'b1;
    wait_valid(300, lat);
    check("bp_valid", int'(bus.valid), 1);
    check("bp_on",  int'(bus.on_count),  10);
    check("bp_off", int'(bus.off_count), 10);
    n_ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK);
      #1;
      if (bus.valid && bus.bnum == 12'd2048) n_ok++;
    end
    check("bp_hold", n_ok, 50);
    @(negedge CLK);
    bus.ready = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_drop", int'(bus.valid), 0);
    check("bp_rearm_busy", int'(bus.busy), 1);
    @(negedge CLK);
    bus.cont = 1'b0;
    wait_valid(300, lat);
    check("cont2_valid", int'(bus.valid), 1);
    check("cont2_bnum", int'(bus.bnum), 2048);
    check("cont2_on",   int'(bus.on_count),  10);
    check("cont2_off",  int'(bus.off_count), 10);
    @(posedge CLK);
    #1;
    check("cont2_idle", int'(bus.busy), 0);
    @(negedge CLK);
    osc_en = 1'b0;
    repeat (4) @(negedge CLK);

    // Timeout: input rises and sticks high.
    pulse_start();
    repeat (2) @(negedge CLK);
    in_drv = 1'b1;
    wait_valid(6000, lat);
    check("to_valid", int'(bus.valid), 1);
    check("to_err",   int'(bus.err), 1);
    check("to_bnum",  int'(bus.bnum), 0);
    check("to_on",    int'(bus.on_count), 4095);
    check("to_off",   int'(bus.off_count), 0);
    @(posedge CLK);
    #1;
    check("to_pulse", int'(bus.valid), 0);
    @(negedge CLK);
    in_drv = 1'b0;
    repeat (4) @(negedge CLK);

    // Reset in the middle of the divide.
    pulse_start();
    repeat (2) @(negedge CLK);
    in_drv = 1'b1;
    repeat (20) @(negedge CLK);
    in_drv = 1'b0;
    repeat (20) @(negedge CLK);
    in_drv = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    check("mid_busy", int'(bus.busy), 1);
    check("mid_novalid", int'(bus.valid), 0);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    check("mid_rst_busy",  int'(bus.busy),      0);
    check("mid_rst_valid", int'(bus.valid),     0);
    check("mid_rst_on",    int'(bus.on_count),  0);
    check("mid_rst_off",   int'(bus.off_count), 0);
    check("mid_rst_bnum",  int'(bus.bnum),      0);
    @(negedge CLK);
    RST_N = 1'b1;
    n_ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (bus.valid || bus.busy) n_ok++;
    end
    check("mid_quiet", n_ok, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
